// File: rtl/score_pkg.sv
// Shared constants, state encoding and point helpers for the score event queue.
package score_pkg;

    localparam int DEPTH_DEFAULT = 8;

    localparam logic [7:0] PTS_ROW_TOP  = 8'd30;
    localparam logic [7:0] PTS_ROW_MID  = 8'd20;
    localparam logic [7:0] PTS_ROW_LOW  = 8'd10;
    localparam logic [7:0] PTS_UFO_BASE = 8'd50;

    // Feedback taps for x^8+x^6+x^5+x^4+1 on a left-shifting register.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } gameState_t;

    function automatic logic [7:0] alienPoints(input logic [2:0] row);
        if (row[2])
            return PTS_ROW_LOW;
        else if (row[1])
            return PTS_ROW_MID;
        else
            return PTS_ROW_TOP;
    endfunction

    function automatic logic [7:0] lfsrNext(input logic [7:0] lfsr);
        return {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
    endfunction

    function automatic logic [7:0] ufoPoints(input logic [7:0] lfsr);
        logic [7:0] mult;
        mult = {6'd0, lfsr[1:0]} + 8'd1;
        return mult * PTS_UFO_BASE;
    endfunction

endpackage

// File: rtl/score_fifo.sv
// Circular buffer of pending score entries; clear wins over push and pop.
module score_fifo
    import score_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rdPtr;
    logic [AW-1:0]    wrPtr;
    logic             doPush;
    logic             doPop;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign dout  = mem[rdPtr];

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign doPop  = pop && !empty && !clear;
    assign doPush = push && (!full || doPop) && !clear;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (clear) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPop)
                rdPtr <= rdPtr + 1'b1;
            if (doPush)
                wrPtr <= wrPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush)
            mem[wrPtr] <= din;
    end

endmodule

// File: rtl/score_event_queue.sv
// Collects alien/UFO hit points and releases one queued entry per frame.
// state | meaning
// IDLE  | no game in progress; hits ignored, queue keeps draining
// RUN   | game in progress; hits are pushed as score entries
module score_event_queue
    import score_pkg::*;
#(
    parameter int         DEPTH     = DEPTH_DEFAULT,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       startGame,
    input  logic       gameOver,
    input  logic       alienHit,
    input  logic [2:0] alienRow,
    input  logic       ufoHit,
    output logic [7:0] scoreUpdate,
    output logic [3:0] pending,
    output logic       overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    gameState_t    state;
    gameState_t    stateNext;
    logic          hitsEnabled;
    logic [7:0]    lfsr;
    logic [7:0]    hitPoints;
    logic          push;
    logic          pop;
    logic [7:0]    headValue;
    logic [CW-1:0] fifoCount;
    logic          fifoFull;
    logic          fifoEmpty;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        if (startGame)
            stateNext = RUN;
        else if (gameOver)
            stateNext = IDLE;
    end

    always_comb begin
        hitsEnabled = 1'b0;
        if (state == RUN)
            hitsEnabled = 1'b1;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            lfsr <= LFSR_SEED;
        else
            lfsr <= lfsrNext(lfsr);
    end

    always_comb begin
        hitPoints = 8'd0;
        if (alienHit)
            hitPoints = hitPoints + alienPoints(alienRow);
        if (ufoHit)
            hitPoints = hitPoints + ufoPoints(lfsr);
    end

    // The startGame cycle belongs to the new game: nothing enters or leaves.
    assign push = hitsEnabled && (alienHit || ufoHit) && !startGame;
    assign pop  = startOfFrame && !startGame;

    score_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8),
        .CW    (CW)
    ) u_fifo (
        .clk    (clk),
        .resetN (resetN),
        .clear  (startGame),
        .push   (push),
        .pop    (pop),
        .din    (hitPoints),
        .dout   (headValue),
        .count  (fifoCount),
        .full   (fifoFull),
        .empty  (fifoEmpty)
    );

    assign pending = 4'(fifoCount);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            scoreUpdate <= 8'd0;
            overflow    <= 1'b0;
        end else if (startGame) begin
            scoreUpdate <= 8'd0;
            overflow    <= 1'b0;
        end else begin
            if (pop)
                scoreUpdate <= fifoEmpty ? 8'd0 : headValue;
            if (push && fifoFull && !pop)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_score_event_queue.sv
// Directed bench with a scoreboard queue of expected frame scores.
module tb_score_event_queue;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       startGame = 1'b0;
    logic       gameOver = 1'b0;
    logic       alienHit = 1'b0;
    logic [2:0] alienRow = 3'd0;
    logic       ufoHit = 1'b0;
    logic [7:0] scoreUpdate;
    logic [3:0] pending;
    logic       overflow;

    int nAsserts = 0;
    int nFails = 0;

    logic [7:0] sbq[$];
    logic [7:0] expScore = 8'd0;
    logic       expOvf = 1'b0;
    bit         expRun = 1'b0;
    logic [7:0] mLfsr;
    logic [7:0] u;

    score_event_queue #(.DEPTH(8), .LFSR_SEED(8'hA5)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .startGame    (startGame),
        .gameOver     (gameOver),
        .alienHit     (alienHit),
        .alienRow     (alienRow),
        .ufoHit       (ufoHit),
        .scoreUpdate  (scoreUpdate),
        .pending      (pending),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, shifting left, feedback into bit 0.
    always @(posedge clk or negedge resetN) begin
        if (!resetN)
            mLfsr <= 8'hA5;
        else
            mLfsr <= {mLfsr[6:0], mLfsr[7] ^ mLfsr[5] ^ mLfsr[4] ^ mLfsr[3]};
    end

    function automatic logic [7:0] rowPts(input logic [2:0] row);
        if (row < 3'd2) return 8'd30;
        if (row < 3'd4) return 8'd20;
        return 8'd10;
    endfunction

    function automatic logic [7:0] ufoPts(input logic [7:0] l);
        return 8'((int'(l[1:0]) + 1) * 50);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        nAsserts++;
        assert (obs === expv) else begin
            nFails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic checkAll(input string tag);
        check({tag, " pending"}, {4'd0, pending}, 8'(sbq.size()));
        check({tag, " score"}, scoreUpdate, expScore);
        check({tag, " overflow"}, {7'd0, overflow}, {7'd0, expOvf});
    endtask

    // One clock: drive inputs, update scoreboard, sample 1 time unit after the edge.
    task automatic cyc(input string tag, input bit sof, input bit sg, input bit go,
                       input bit ah, input logic [2:0] row, input bit uh);
        logic [7:0] pts;
        bit wasFull;
        startOfFrame = sof; startGame = sg; gameOver = go;
        alienHit = ah; alienRow = row; ufoHit = uh;
        pts = 8'd0;
        if (ah) pts = pts + rowPts(row);
        if (uh) pts = pts + ufoPts(mLfsr);
        if (sg) begin
            sbq.delete();
            expScore = 8'd0;
            expOvf = 1'b0;
            expRun = 1'b1;
        end else begin
            wasFull = (sbq.size() == 8);
            if (sof) begin
                if (sbq.size() > 0) expScore = sbq.pop_front();
                else expScore = 8'd0;
            end
            if (expRun && (ah || uh)) begin
                if (!wasFull || sof) sbq.push_back(pts);
                else expOvf = 1'b1;
            end
            if (go) expRun = 1'b0;
        end
        @(posedge clk);
        #1;
        startOfFrame = 0; startGame = 0; gameOver = 0; alienHit = 0; ufoHit = 0; alienRow = 0;
        checkAll(tag);
    endtask

    initial begin
        #22;
        check("reset pending", {4'd0, pending}, 8'd0);
        check("reset score", scoreUpdate, 8'd0);
        check("reset overflow", {7'd0, overflow}, 8'd0);
        resetN = 1'b1;
        @(posedge clk); #1;

        // Hits in IDLE are ignored.
        cyc("idle hit", 0, 0, 0, 1, 3'd0, 0);
        cyc("idle ufo", 0, 0, 0, 0, 3'd0, 1);
        check("idle no push", {4'd0, pending}, 8'd0);

        // Single alien, row 0.
        cyc("start1", 0, 1, 0, 0, 3'd0, 0);
        cyc("row0 hit", 0, 0, 0, 1, 3'd0, 0);
        check("row0 pending1", {4'd0, pending}, 8'd1);
        cyc("row0 sof", 1, 0, 0, 0, 3'd0, 0);
        check("row0 score30", scoreUpdate, 8'd30);
        check("row0 pending0", {4'd0, pending}, 8'd0);
        for (int i = 0; i < 3; i++) cyc("row0 hold", 0, 0, 0, 0, 3'd0, 0);
        check("row0 held", scoreUpdate, 8'd30);
        cyc("row0 sof2", 1, 0, 0, 0, 3'd0, 0);
        check("row0 score0", scoreUpdate, 8'd0);

        // Overflow: nine row-5 hits.
        for (int i = 0; i < 9; i++) cyc("ovf push", 0, 0, 0, 1, 3'd5, 0);
        check("ovf pending8", {4'd0, pending}, 8'd8);
        check("ovf flag", {7'd0, overflow}, 8'd1);
        for (int i = 0; i < 8; i++) begin
            cyc("ovf drain", 1, 0, 0, 0, 3'd0, 0);
            check("ovf score10", scoreUpdate, 8'd10);
            cyc("ovf gap", 0, 0, 0, 0, 3'd0, 0);
        end
        cyc("ovf empty sof", 1, 0, 0, 0, 3'd0, 0);

        // Row mapping sweep.
        for (int r = 0; r < 8; r++) cyc("rows push", 0, 0, 0, 1, 3'(r), 0);
        for (int r = 0; r < 8; r++) cyc("rows pop", 1, 0, 0, 0, 3'd0, 0);

        // Alien row 2 plus UFO in the same cycle.
        for (int k = 0; k < 4; k++) begin
            u = ufoPts(mLfsr);
            cyc("combo push", 0, 0, 0, 1, 3'd2, 1);
            check("combo pending1", {4'd0, pending}, 8'd1);
            cyc("combo sof", 1, 0, 0, 0, 3'd0, 0);
            check("combo score", scoreUpdate, 8'd20 + u);
            repeat (k + 1) cyc("combo gap", 0, 0, 0, 0, 3'd0, 0);
        end
        cyc("ufo only", 0, 0, 0, 0, 3'd0, 1);
        cyc("ufo only sof", 1, 0, 0, 0, 3'd0, 0);

        // Push and pop together on a full queue.
        cyc("start2", 0, 1, 0, 0, 3'd0, 0);
        for (int i = 0; i < 8; i++) cyc("full fill", 0, 0, 0, 1, 3'(i), 0);
        cyc("full pushpop", 1, 0, 0, 1, 3'd3, 0);
        check("full pending8", {4'd0, pending}, 8'd8);
        check("full no ovf", {7'd0, overflow}, 8'd0);
        for (int i = 0; i < 9; i++) cyc("full drain", 1, 0, 0, 0, 3'd0, 0);

        // startGame flushes three entries and a live score.
        for (int i = 0; i < 4; i++) cyc("flush push", 0, 0, 0, 1, 3'd1, 0);
        cyc("flush sof", 1, 0, 0, 0, 3'd0, 0);
        cyc("flush start", 1, 1, 0, 1, 3'd0, 0);
        check("flush pending0", {4'd0, pending}, 8'd0);
        check("flush score0", scoreUpdate, 8'd0);
        check("flush ovf0", {7'd0, overflow}, 8'd0);

        // gameOver: queued points keep draining, later hits ignored.
        cyc("go push", 0, 0, 0, 1, 3'd0, 0);
        cyc("go push2", 0, 0, 1, 1, 3'd7, 0);
        cyc("go idle hit", 0, 0, 0, 1, 3'd0, 0);
        cyc("go both", 0, 1, 1, 0, 3'd0, 0);
        cyc("go run hit", 0, 0, 1, 1, 3'd4, 0);
        cyc("go idle hit2", 0, 0, 0, 1, 3'd4, 0);
        cyc("go drain", 1, 0, 0, 0, 3'd0, 0);
        check("go delivered", scoreUpdate, 8'd10);
        cyc("go drain2", 1, 0, 0, 0, 3'd0, 0);

        // Asynchronous reset mid-frame with five entries queued.
        cyc("rst start", 0, 1, 0, 0, 3'd0, 0);
        for (int i = 0; i < 6; i++) cyc("rst push", 0, 0, 0, 1, 3'd2, 0);
        cyc("rst sof", 1, 0, 0, 0, 3'd0, 0);
        #2;
        resetN = 1'b0;
        #1;
        check("async pending", {4'd0, pending}, 8'd0);
        check("async score", scoreUpdate, 8'd0);
        check("async overflow", {7'd0, overflow}, 8'd0);
        sbq.delete();
        expScore = 8'd0;
        expOvf = 1'b0;
        expRun = 1'b0;
        #10;
        resetN = 1'b1;
        @(posedge clk); #1;
        cyc("post rst idle", 0, 0, 0, 1, 3'd0, 0);
        cyc("post rst start", 0, 1, 0, 0, 3'd0, 0);
        u = ufoPts(mLfsr);
        cyc("post rst ufo", 0, 0, 0, 0, 3'd0, 1);
        cyc("post rst sof", 1, 0, 0, 0, 3'd0, 0);
        check("post rst ufo pts", scoreUpdate, u);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
